uart_frame_counter: RTL and testbench

UART_FRAME_COUNTER -- requirements
Module: uart_frame_counter

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_frame_chan.sv | 156 +++++++++++++++
 rtl/uart_frame_counter.sv | 75 +++++++
 tb/tb_uart_frame_counter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing definitions: frame phase encoding, channel mode
// and the data-bit clamp used when a frame's configuration is latched.
package uart_pkg;

  typedef enum logic [1:0] {
    PH_START  = 2'd0,
    PH_DATA   = 2'd1,
    PH_PARITY = 2'd2,
    PH_STOP   = 2'd3
  } phase_t;

  typedef enum logic {
    MODE_TX = 1'b0,
    MODE_RX = 1'b1
  } chan_mode_t;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_ACTIVE = 2'd1,
    CH_FINISH = 2'd2
  } chan_state_t;

  localparam logic [3:0] DATA_BITS_MIN   = 4'd5;
  localparam logic [3:0] DATA_BITS_LIMIT = 4'd9;

  // Out-of-range requests saturate rather than wrap.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < DATA_BITS_MIN) begin
      return DATA_BITS_MIN;
    end
    if (req > max_bits) begin
      return max_bits;
    end
    return req;
  endfunction

endpackage

// File: rtl/uart_frame_chan.sv
// One UART framing channel: sequences START/DATA/PARITY/STOP bit periods
// from the shared oversample strobe. MODE selects transmit or receive timing.
module uart_frame_chan
  import uart_pkg::*;
#(
  parameter chan_mode_t MODE          = MODE_TX,
  parameter int         OVERSAMPLE    = 16,
  parameter int         DATA_BITS_MAX = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       start,
  input  logic [3:0] cfg_data_bits,
  input  logic       cfg_parity_en,
  input  logic       cfg_stop2,
  input  logic       line_in,
  output logic       busy,
  output logic [1:0] phase,
  output logic [3:0] bit_idx,
  output logic       strobe,
  output logic       done,
  output logic       abort
);

  localparam int              TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]   TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      BITS_MAX  = 4'(DATA_BITS_MAX);

  chan_state_t   state_reg;
  phase_t        phase_reg;
  logic [TW-1:0] tick_reg;
  logic [3:0]    bit_idx_reg;
  logic [3:0]    bits_reg;
  logic          parity_reg;
  logic          stop2_reg;
  logic          second_stop_reg;
  logic          busy_reg;
  logic          strobe_reg;
  logic          done_reg;
  logic          abort_reg;

  logic bit_end;
  logic mid_tick;

  assign bit_end  = baud_tick && (tick_reg == TICK_LAST);
  assign mid_tick = baud_tick && (tick_reg == TICK_MID);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= CH_IDLE;
      phase_reg       <= PH_START;
      tick_reg        <= '0;
      bit_idx_reg     <= '0;
      bits_reg        <= '0;
      parity_reg      <= 1'b0;
      stop2_reg       <= 1'b0;
      second_stop_reg <= 1'b0;
      busy_reg        <= 1'b0;
      strobe_reg      <= 1'b0;
      done_reg        <= 1'b0;
      abort_reg       <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      done_reg   <= 1'b0;
      abort_reg  <= 1'b0;
      case (state_reg)
        CH_IDLE: begin
          if (start) begin
            state_reg       <= CH_ACTIVE;
            busy_reg        <= 1'b1;
            phase_reg       <= PH_START;
            tick_reg        <= '0;
            bit_idx_reg     <= '0;
            bits_reg        <= clamp_data_bits(cfg_data_bits, BITS_MAX);
            parity_reg      <= cfg_parity_en;
            stop2_reg       <= cfg_stop2;
            second_stop_reg <= 1'b0;
          end
        end

        CH_ACTIVE: begin
          if (baud_tick) begin
            tick_reg <= bit_end ? '0 : tick_reg + TW'(1);
          end

          // Receive decisions are taken at mid-bit; the stop bit is not waited out.
          if (MODE == MODE_RX && mid_tick) begin
            strobe_reg <= 1'b1;
            if (phase_reg == PH_START && line_in) begin
              abort_reg <= 1'b1;
              state_reg <= CH_FINISH;
            end else if (phase_reg == PH_STOP) begin
              done_reg  <= 1'b1;
              state_reg <= CH_FINISH;
            end
          end

          if (MODE == MODE_TX && bit_end) begin
            strobe_reg <= 1'b1;
          end

          if (bit_end) begin
            case (phase_reg)
              PH_START: phase_reg <= PH_DATA;
              PH_DATA: begin
                if (bit_idx_reg == bits_reg - 4'd1) begin
                  bit_idx_reg <= '0;
                  phase_reg   <= parity_reg ? PH_PARITY : PH_STOP;
                end else begin
                  bit_idx_reg <= bit_idx_reg + 4'd1;
                end
              end
              PH_PARITY: phase_reg <= PH_STOP;
              PH_STOP: begin
                if (MODE == MODE_TX) begin
                  if (stop2_reg && !second_stop_reg) begin
                    second_stop_reg <= 1'b1;
                  end else begin
                    done_reg  <= 1'b1;
                    state_reg <= CH_FINISH;
                  end
                end
              end
              default: phase_reg <= PH_START;
            endcase
          end
        end

        // Completion cycle: still busy so a start coincident with done is dropped.
        CH_FINISH: begin
          state_reg   <= CH_IDLE;
          busy_reg    <= 1'b0;
          phase_reg   <= PH_START;
          tick_reg    <= '0;
          bit_idx_reg <= '0;
        end

        default: begin
          state_reg <= CH_IDLE;
          busy_reg  <= 1'b0;
          phase_reg <= PH_START;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign phase   = phase_reg;
  assign bit_idx = bit_idx_reg;
  assign strobe  = strobe_reg;
  assign done    = done_reg;
  assign abort   = abort_reg;

endmodule

// File: rtl/uart_frame_counter.sv
// UART frame sequencer: independent, concurrent transmit and receive
// framing channels sharing one oversample strobe and one frame configuration.
module uart_frame_counter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS_MAX = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic [3:0] cfg_data_bits,
  input  logic       cfg_parity_en,
  input  logic       cfg_stop2,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic [1:0] tx_phase,
  output logic [3:0] tx_bit_idx,
  output logic       tx_shift,
  output logic       tx_done,
  input  logic       rx_start,
  input  logic       rx_in,
  output logic       rx_busy,
  output logic [1:0] rx_phase,
  output logic [3:0] rx_bit_idx,
  output logic       rx_sample,
  output logic       rx_done,
  output logic       rx_false_start
);

  logic tx_abort_unused;

  uart_frame_chan #(
    .MODE          (MODE_TX),
    .OVERSAMPLE    (OVERSAMPLE),
    .DATA_BITS_MAX (DATA_BITS_MAX)
  ) u_tx (
    .clock         (clock),
    .reset         (reset),
    .baud_tick     (baud_tick),
    .start         (tx_start),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity_en (cfg_parity_en),
    .cfg_stop2     (cfg_stop2),
    .line_in       (1'b1),
    .busy          (tx_busy),
    .phase         (tx_phase),
    .bit_idx       (tx_bit_idx),
    .strobe        (tx_shift),
    .done          (tx_done),
    .abort         (tx_abort_unused)
  );

  uart_frame_chan #(
    .MODE          (MODE_RX),
    .OVERSAMPLE    (OVERSAMPLE),
    .DATA_BITS_MAX (DATA_BITS_MAX)
  ) u_rx (
    .clock         (clock),
    .reset         (reset),
    .baud_tick     (baud_tick),
    .start         (rx_start),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity_en (cfg_parity_en),
    .cfg_stop2     (cfg_stop2),
    .line_in       (rx_in),
    .busy          (rx_busy),
    .phase         (rx_phase),
    .bit_idx       (rx_bit_idx),
    .strobe        (rx_sample),
    .done          (rx_done),
    .abort         (rx_false_start)
  );

endmodule

// File: tb/tb_uart_frame_counter.sv
// Scoreboard bench for uart_frame_counter: stimulus pushes expected pulse
// times/phases into queues, a negedge monitor pops and compares each pulse.
module tb_uart_frame_counter;

  localparam int OS = 16;
  localparam int NQ = 7;
  localparam int Q_TX_SHIFT = 0, Q_TX_DONE = 1, Q_TX_FALL = 2;
  localparam int Q_RX_SAMPLE = 3, Q_RX_DONE = 4, Q_RX_FALSE = 5, Q_RX_FALL = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b1;
  logic [3:0] cfg_data_bits = 4'd8;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic       tx_start = 1'b0;
  logic       rx_start = 1'b0;
  logic       rx_in = 1'b1;
  logic       tx_busy, tx_shift, tx_done, rx_busy, rx_sample, rx_done, rx_false_start;
  logic [1:0] tx_phase, rx_phase;
  logic [3:0] tx_bit_idx, rx_bit_idx;

  uart_frame_counter #(.OVERSAMPLE(OS), .DATA_BITS_MAX(9)) dut (
    .clock(clock), .reset(reset), .baud_tick(baud_tick),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en), .cfg_stop2(cfg_stop2),
    .tx_start(tx_start), .tx_busy(tx_busy), .tx_phase(tx_phase), .tx_bit_idx(tx_bit_idx),
    .tx_shift(tx_shift), .tx_done(tx_done),
    .rx_start(rx_start), .rx_in(rx_in), .rx_busy(rx_busy), .rx_phase(rx_phase),
    .rx_bit_idx(rx_bit_idx), .rx_sample(rx_sample), .rx_done(rx_done),
    .rx_false_start(rx_false_start)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ph;
    int idx;
  } ev_t;

  ev_t q[NQ][$];
  int  errors = 0;
  int  checks = 0;
  logic tx_busy_prev = 1'b0;
  logic rx_busy_prev = 1'b0;

  function automatic string ev_name(input int k);
    case (k)
      Q_TX_SHIFT:  return "tx_shift";
      Q_TX_DONE:   return "tx_done";
      Q_TX_FALL:   return "tx_busy_fall";
      Q_RX_SAMPLE: return "rx_sample";
      Q_RX_DONE:   return "rx_done";
      Q_RX_FALSE:  return "rx_false_start";
      default:     return "rx_busy_fall";
    endcase
  endfunction

  task automatic observe(input int k, input logic fire, input logic [1:0] ph, input logic [3:0] idx);
    ev_t e;
    if (fire === 1'b1) begin
      checks++;
      if (q[k].size() == 0) begin
        errors++;
        $display("FAIL %s unexpected at cyc=%0d (phase=%0d idx=%0d), required none", ev_name(k), cyc, ph, idx);
      end else begin
        e = q[k].pop_front();
        if (e.cyc != cyc || (e.ph >= 0 && e.ph != int'(ph)) || (e.idx >= 0 && e.idx != int'(idx))) begin
          errors++;
          $display("FAIL %s got cyc=%0d phase=%0d idx=%0d, required cyc=%0d phase=%0d idx=%0d",
                   ev_name(k), cyc, ph, idx, e.cyc, e.ph, e.idx);
        end else begin
          $display("cyc=%0d %s ok phase=%0d idx=%0d", cyc, ev_name(k), ph, idx);
        end
      end
    end
  endtask

  always @(negedge clock) begin
    observe(Q_TX_SHIFT, tx_shift, tx_phase, tx_bit_idx);
    observe(Q_TX_DONE, tx_done, tx_phase, tx_bit_idx);
    observe(Q_TX_FALL, tx_busy_prev && !tx_busy, tx_phase, tx_bit_idx);
    observe(Q_RX_SAMPLE, rx_sample, rx_phase, rx_bit_idx);
    observe(Q_RX_DONE, rx_done, rx_phase, rx_bit_idx);
    observe(Q_RX_FALSE, rx_false_start, rx_phase, rx_bit_idx);
    observe(Q_RX_FALL, rx_busy_prev && !rx_busy, rx_phase, rx_bit_idx);
    tx_busy_prev <= tx_busy;
    rx_busy_prev <= rx_busy;
  end

  task automatic push(input int k, input int c, input int ph, input int idx);
    ev_t e;
    e.cyc = c;
    e.ph  = ph;
    e.idx = idx;
    q[k].push_back(e);
  endtask

  // Frame position 0 is START, 1..n are data bits, then optional parity, then stop.
  function automatic int pos_phase(input int pos, input int n, input bit par);
    if (pos == 0) return 0;
    if (pos <= n) return 1;
    if (par && pos == n + 1) return 2;
    return 3;
  endfunction

  function automatic int pos_idx(input int pos, input int n);
    return (pos >= 1 && pos <= n) ? pos - 1 : 0;
  endfunction

  task automatic push_tx(input int s, input int n, input bit par, input bit st2);
    int total;
    total = 1 + n + int'(par) + (st2 ? 2 : 1);
    for (int k = 1; k <= total; k++) begin
      if (k < total) push(Q_TX_SHIFT, s + OS * k, pos_phase(k, n, par), pos_idx(k, n));
      else           push(Q_TX_SHIFT, s + OS * k, 3, 0);
    end
    push(Q_TX_DONE, s + OS * total, 3, 0);
    push(Q_TX_FALL, s + OS * total + 1, -1, -1);
  endtask

  task automatic push_rx(input int s, input int n, input bit par);
    int total;
    total = 1 + n + int'(par) + 1;
    for (int k = 0; k < total; k++) begin
      push(Q_RX_SAMPLE, s + OS * k + OS / 2, pos_phase(k, n, par), pos_idx(k, n));
    end
    push(Q_RX_DONE, s + OS * (total - 1) + OS / 2, 3, 0);
    push(Q_RX_FALL, s + OS * (total - 1) + OS / 2 + 1, -1, -1);
  endtask

  task automatic pulse_start(input bit do_tx, input bit do_rx, output int s);
    @(negedge clock);
    tx_start = do_tx;
    rx_start = do_rx;
    s = cyc + 1;
    @(negedge clock);
    tx_start = 1'b0;
    rx_start = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d, required %0d", nm, act, exp);
    end else begin
      $display("cyc=%0d %s ok value=%0d", cyc, nm, act);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < NQ; k++) n += q[k].size();
    return n;
  endfunction

  task automatic wait_drain(input string nm, input int limit);
    int n = 0;
    while (pending() != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (pending() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout with %0d expected events outstanding, required 0", nm, pending());
      for (int k = 0; k < NQ; k++) q[k].delete();
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic set_cfg(input logic [3:0] n, input bit par, input bit st2);
    cfg_data_bits = n;
    cfg_parity_en = par;
    cfg_stop2     = st2;
  endtask

  int s;
  logic [23:0] all_out;

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_tx_busy", int'(tx_busy), 0);
    chk("reset_tx_phase", int'(tx_phase), 0);
    chk("reset_rx_busy", int'(rx_busy), 0);
    chk("reset_rx_bit_idx", int'(rx_bit_idx), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 8N1 transmit: ten shifts 16 clocks apart, done 160 after start entry.
    set_cfg(4'd8, 1'b0, 1'b0);
    pulse_start(1'b1, 1'b0, s);
    push_tx(s, 8, 1'b0, 1'b0);
    chk("tx_busy_at_start", int'(tx_busy), 1);
    wait_drain("tx_8n1", 400);

    // 7E2 transmit: eleven bit periods, parity phase after bit index 6.
    set_cfg(4'd7, 1'b1, 1'b1);
    pulse_start(1'b1, 1'b0, s);
    push_tx(s, 7, 1'b1, 1'b1);
    while (cyc < s + 130) @(negedge clock);
    chk("tx_phase_parity", int'(tx_phase), 2);
    wait_drain("tx_7e2", 400);

    // 8N1 receive with start bit low; a second rx_start mid-frame is ignored.
    set_cfg(4'd8, 1'b0, 1'b0);
    rx_in = 1'b0;
    pulse_start(1'b0, 1'b1, s);
    push_rx(s, 8, 1'b0);
    repeat (30) @(negedge clock);
    rx_start = 1'b1;
    @(negedge clock);
    rx_start = 1'b0;
    wait_drain("rx_8n1", 400);
    rx_in = 1'b1;

    // False start: line high at the start sample.
    pulse_start(1'b0, 1'b1, s);
    push(Q_RX_SAMPLE, s + 8, 0, 0);
    push(Q_RX_FALSE, s + 8, 0, 0);
    push(Q_RX_FALL, s + 9, -1, -1);
    wait_drain("rx_false_start", 100);

    // Clamping: 3 -> 5 data bits, 15 -> 9 data bits.
    set_cfg(4'd3, 1'b0, 1'b0);
    pulse_start(1'b1, 1'b0, s);
    push_tx(s, 5, 1'b0, 1'b0);
    wait_drain("tx_clamp_low", 400);
    set_cfg(4'd15, 1'b0, 1'b0);
    pulse_start(1'b1, 1'b0, s);
    push_tx(s, 9, 1'b0, 1'b0);
    wait_drain("tx_clamp_high", 400);

    // Mid-frame cfg change and starts while busy / in the done cycle are ignored.
    set_cfg(4'd8, 1'b0, 1'b0);
    pulse_start(1'b1, 1'b0, s);
    push_tx(s, 8, 1'b0, 1'b0);
    while (cyc < s + 40) @(negedge clock);
    set_cfg(4'd5, 1'b1, 1'b1);
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    while (cyc < s + 160) @(negedge clock);
    chk("tx_done_cycle_busy", int'(tx_busy), 1);
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    wait_drain("tx_cfg_change", 400);

    // Concurrent TX and RX accepted in the same cycle, 6E1.
    set_cfg(4'd6, 1'b1, 1'b0);
    rx_in = 1'b0;
    pulse_start(1'b1, 1'b1, s);
    push_tx(s, 6, 1'b1, 1'b0);
    push_rx(s, 6, 1'b1);
    wait_drain("concurrent_6e1", 400);

    // Reset during TX data bit 4 aborts both channels with no done pulses.
    set_cfg(4'd8, 1'b0, 1'b0);
    pulse_start(1'b1, 1'b1, s);
    push_tx(s, 8, 1'b0, 1'b0);
    push_rx(s, 8, 1'b0);
    while (cyc < s + 85) @(negedge clock);
    chk("tx_bit_idx_before_reset", int'(tx_bit_idx), 4);
    reset = 1'b1;
    for (int k = 0; k < NQ; k++) q[k].delete();
    push(Q_TX_FALL, cyc + 1, -1, -1);
    push(Q_RX_FALL, cyc + 1, -1, -1);
    @(negedge clock);
    all_out = {tx_busy, tx_phase, tx_bit_idx, tx_shift, tx_done, rx_busy, rx_phase,
               rx_bit_idx, rx_sample, rx_done, rx_false_start, 2'b00};
    chk("outputs_after_reset", int'(all_out), 0);
    reset = 1'b0;
    rx_in = 1'b1;
    wait_drain("reset_abort", 20);
    pulse_start(1'b1, 1'b0, s);
    push_tx(s, 8, 1'b0, 1'b0);
    wait_drain("tx_after_reset", 400);

    for (int k = 0; k < NQ; k++) begin
      if (q[k].size() != 0) begin
        checks++;
        errors++;
        $display("FAIL %s leftover got %0d events, required 0", ev_name(k), q[k].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
